// File: rtl/fb_scanout.sv
// fb_scanout: SVGA raster timing and sequential framebuffer reads for the 6-bit framebuffer.
// Pixels are expanded 2:2:2 -> 4:4:4 and leave aligned with hsync/vsync, two PIX_EN ticks behind the counters.
module fb_scanout #(
  parameter int unsigned H_ACTIVE = 800,
  parameter int unsigned H_FP     = 56,
  parameter int unsigned H_SYNC   = 120,
  parameter int unsigned H_BP     = 64,
  parameter int unsigned V_ACTIVE = 600,
  parameter int unsigned V_FP     = 37,
  parameter int unsigned V_SYNC   = 6,
  parameter int unsigned V_BP     = 23,
  parameter bit          SYNC_POL = 1'b1
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        PIX_EN,
  input  logic [5:0]  fb_data,
  output logic [18:0] fb_addr,
  output logic [10:0] h_cnt,
  output logic [9:0]  v_cnt,
  output logic        vblank,
  output logic        frame_tick,
  output logic        vga_h_out,
  output logic        vga_v_out,
  output logic [11:0] vga_data
);

  localparam int unsigned H_W     = 11;
  localparam int unsigned V_W     = 10;
  localparam int unsigned A_W     = 19;
  localparam int unsigned RGB_W   = 12;
  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [H_W-1:0] H_LAST   = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST   = V_W'(V_TOTAL - 1);
  localparam logic [H_W-1:0] H_ACT    = H_W'(H_ACTIVE);
  localparam logic [V_W-1:0] V_ACT    = V_W'(V_ACTIVE);
  localparam logic [H_W-1:0] HS_FIRST = H_W'(H_ACTIVE + H_FP);
  localparam logic [H_W-1:0] HS_LAST  = H_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [V_W-1:0] VS_FIRST = V_W'(V_ACTIVE + V_FP);
  localparam logic [V_W-1:0] VS_LAST  = V_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  logic [H_W-1:0]   r_h_cnt;
  logic [V_W-1:0]   r_v_cnt;
  logic [A_W-1:0]   r_addr_ctr;
  logic [A_W-1:0]   r_fb_addr;
  logic             r_active_d1;
  logic             r_hs_d1;
  logic             r_vs_d1;
  logic             r_h_out;
  logic             r_v_out;
  logic [RGB_W-1:0] r_vga_data;

  logic             w_h_last;
  logic             w_v_last;
  logic             w_active;
  logic             w_hsync_raw;
  logic             w_vsync_raw;
  logic [RGB_W-1:0] w_expanded;

  // Region decode from the pre-update counters.
  assign w_h_last    = (r_h_cnt == H_LAST);
  assign w_v_last    = (r_v_cnt == V_LAST);
  assign w_active    = (r_h_cnt < H_ACT) && (r_v_cnt < V_ACT);
  assign w_hsync_raw = (r_h_cnt >= HS_FIRST) && (r_h_cnt <= HS_LAST);
  assign w_vsync_raw = (r_v_cnt >= VS_FIRST) && (r_v_cnt <= VS_LAST);

  // Each 2-bit component is replicated, so 2'b11 maps to full scale 4'hF.
  assign w_expanded = {fb_data[5:4], fb_data[5:4],
                       fb_data[3:2], fb_data[3:2],
                       fb_data[1:0], fb_data[1:0]};

  // Raster counters.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_h_cnt <= '0;
      r_v_cnt <= '0;
    end else if (PIX_EN) begin
      if (w_h_last) begin
        r_h_cnt <= '0;
        r_v_cnt <= w_v_last ? '0 : r_v_cnt + V_W'(1);
      end else begin
        r_h_cnt <= r_h_cnt + H_W'(1);
      end
    end
  end

  // Linear read address: advances only over visible pixels, so no v*H_ACTIVE product is needed.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_addr_ctr <= '0;
      r_fb_addr  <= '0;
    end else if (PIX_EN) begin
      if (w_active) begin
        r_fb_addr  <= r_addr_ctr;
        r_addr_ctr <= r_addr_ctr + A_W'(1);
      end
      if (w_h_last && w_v_last) begin
        r_addr_ctr <= '0;
      end
    end
  end

  // Stage 1 delays the decodes to line up with the read data.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_active_d1 <= 1'b0;
      r_hs_d1     <= 1'b0;
      r_vs_d1     <= 1'b0;
    end else if (PIX_EN) begin
      r_active_d1 <= w_active;
      r_hs_d1     <= w_hsync_raw;
      r_vs_d1     <= w_vsync_raw;
    end
  end

  // Stage 2: colour and sync registered together at the connector.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_vga_data <= '0;
      r_h_out    <= ~SYNC_POL;
      r_v_out    <= ~SYNC_POL;
    end else if (PIX_EN) begin
      r_vga_data <= r_active_d1 ? w_expanded : '0;
      r_h_out    <= r_hs_d1 ~^ SYNC_POL;
      r_v_out    <= r_vs_d1 ~^ SYNC_POL;
    end
  end

  assign fb_addr    = r_fb_addr;
  assign h_cnt      = r_h_cnt;
  assign v_cnt      = r_v_cnt;
  assign vga_data   = r_vga_data;
  assign vga_h_out  = r_h_out;
  assign vga_v_out  = r_v_out;
  assign vblank     = (r_v_cnt >= V_ACT);
  assign frame_tick = PIX_EN && !RESET && (r_h_cnt == '0) && (r_v_cnt == V_ACT);

endmodule

// File: tb/tb_fb_scanout.sv
// Bench for fb_scanout: a full-size instance and a shrunken-timing instance share stimulus
// and are compared every cycle against a position-based model, plus vector tables and corner sequences.
module tb_fb_scanout;

  typedef struct packed {
    int unsigned ha; int unsigned hf; int unsigned hs; int unsigned hb;
    int unsigned va; int unsigned vf; int unsigned vs; int unsigned vb;
  } cfg_t;

  localparam cfg_t C_BIG   = '{800, 56, 120, 64, 600, 37, 6, 23};
  localparam cfg_t C_SMALL = '{16, 3, 5, 4, 6, 2, 2, 3};

  typedef struct {
    int unsigned n;
    logic [10:0] h;
    logic [9:0]  v;
    logic [18:0] a;
    logic [11:0] d;
    logic        ho;
  } vec_t;

  logic CLK, RESET, PIX_EN;
  logic [5:0]  b_fd, s_fd;
  logic [18:0] b_a, s_a;
  logic [10:0] b_h, s_h;
  logic [9:0]  b_v, s_v;
  logic        b_vb, s_vb, b_ft, s_ft, b_ho, s_ho, b_vo, s_vo;
  logic [11:0] b_d, s_d;

  int unsigned n;
  int checks, failures;
  int unsigned s_ft_count;
  int unsigned s_ft_n[$];
  vec_t tbl [14];

  // Synchronous RAM whose address register is the scanout's fb_addr; word contents = address[5:0].
  assign b_fd = b_a[5:0];
  assign s_fd = s_a[5:0];

  fb_scanout u_big (
    .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN), .fb_data(b_fd), .fb_addr(b_a),
    .h_cnt(b_h), .v_cnt(b_v), .vblank(b_vb), .frame_tick(b_ft),
    .vga_h_out(b_ho), .vga_v_out(b_vo), .vga_data(b_d)
  );

  fb_scanout #(
    .H_ACTIVE(16), .H_FP(3), .H_SYNC(5), .H_BP(4),
    .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3), .SYNC_POL(1'b1)
  ) u_small (
    .CLK(CLK), .RESET(RESET), .PIX_EN(PIX_EN), .fb_data(s_fd), .fb_addr(s_a),
    .h_cnt(s_h), .v_cnt(s_v), .vblank(s_vb), .frame_tick(s_ft),
    .vga_h_out(s_ho), .vga_v_out(s_vo), .vga_data(s_d)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  initial begin
    #2000000;
    $display("FAIL watchdog timeout n=%0d", n);
    $fatal(1, "watchdog");
  end

  function automatic int unsigned m_ht(input cfg_t c);
    return c.ha + c.hf + c.hs + c.hb;
  endfunction

  function automatic int unsigned m_fr(input cfg_t c);
    return m_ht(c) * (c.va + c.vf + c.vs + c.vb);
  endfunction

  // 2-bit component c shows as 5*c on 4 bits.
  function automatic int unsigned m_rgb(input int unsigned d6);
    return 5 * (d6 / 16) * 256 + 5 * ((d6 / 4) % 4) * 16 + 5 * (d6 % 4);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h n=%0d", name, act, exp, n);
    end
  endtask

  // After n PIX_EN ticks since reset, counters sit at position n; fb_addr holds the last visible
  // position before n; colour/sync describe position n-2.
  task automatic chk_inst(input string tag, input cfg_t c, input logic [10:0] h, input logic [9:0] v,
                          input logic [18:0] a, input logic [11:0] d, input logic ho,
                          input logic vo, input logic vb);
    int unsigned ht, fr, p, ph, pv, ea, ed;
    logic eho, evo;
    ht = m_ht(c);
    fr = m_fr(c);
    p  = n % fr; ph = p % ht; pv = p / ht;
    chk({tag, "_h_cnt"}, 32'(h), ph);
    chk({tag, "_v_cnt"}, 32'(v), pv);
    chk({tag, "_vblank"}, 32'(vb), 32'(pv >= c.va));
    ea = 0;
    if (n > 0) begin
      p = (n - 1) % fr; ph = p % ht; pv = p / ht;
      if (pv >= c.va)     ea = c.va * c.ha - 1;
      else if (ph < c.ha) ea = pv * c.ha + ph;
      else                ea = pv * c.ha + c.ha - 1;
    end
    chk({tag, "_fb_addr"}, 32'(a), ea);
    ed = 0; eho = 1'b0; evo = 1'b0;
    if (n >= 2) begin
      p = (n - 2) % fr; ph = p % ht; pv = p / ht;
      if (ph < c.ha && pv < c.va) ed = m_rgb((pv * c.ha + ph) % 64);
      eho = (ph >= c.ha + c.hf) && (ph < c.ha + c.hf + c.hs);
      evo = (pv >= c.va + c.vf) && (pv < c.va + c.vf + c.vs);
    end
    chk({tag, "_vga_data"}, 32'(d), ed);
    chk({tag, "_vga_h_out"}, 32'(ho), 32'(eho));
    chk({tag, "_vga_v_out"}, 32'(vo), 32'(evo));
  endtask

  // One CLK: drive inputs, check the combinational frame_tick, clock, then check registered state.
  task automatic step(input logic pe, input logic rst);
    @(negedge CLK);
    PIX_EN = pe;
    RESET  = rst;
    #1;
    chk("b_frame_tick", 32'(b_ft), 32'(pe && !rst && (n % m_fr(C_BIG)) == C_BIG.va * m_ht(C_BIG)));
    chk("s_frame_tick", 32'(s_ft), 32'(pe && !rst && (n % m_fr(C_SMALL)) == C_SMALL.va * m_ht(C_SMALL)));
    if (s_ft === 1'b1) begin
      s_ft_count++;
      s_ft_n.push_back(n);
    end
    @(posedge CLK);
    #1;
    if (rst) n = 0;
    else if (pe) n++;
    chk_inst("b", C_BIG, b_h, b_v, b_a, b_d, b_ho, b_vo, b_vb);
    chk_inst("s", C_SMALL, s_h, s_v, s_a, s_d, s_ho, s_vo, s_vb);
  endtask

  initial begin
    int idx;
    int unsigned bh_cnt, svb_cnt, svs_cnt;
    checks = 0; failures = 0; n = 0;
    s_ft_count = 0; bh_cnt = 0; svb_cnt = 0; svs_cnt = 0;

    // Full-size vectors at PIX_EN tied high: {ticks since reset, h, v, fb_addr, vga_data, vga_h_out}.
    tbl[0]  = '{1,    11'd1,   10'd0, 19'd0,   12'h000, 1'b0};
    tbl[1]  = '{2,    11'd2,   10'd0, 19'd1,   12'h000, 1'b0};
    tbl[2]  = '{5,    11'd5,   10'd0, 19'd4,   12'h00F, 1'b0};
    tbl[3]  = '{17,   11'd17,  10'd0, 19'd16,  12'h0FF, 1'b0};
    tbl[4]  = '{50,   11'd50,  10'd0, 19'd49,  12'hF00, 1'b0};
    tbl[5]  = '{801,  11'd801, 10'd0, 19'd799, 12'h5FF, 1'b0};
    tbl[6]  = '{802,  11'd802, 10'd0, 19'd799, 12'h000, 1'b0};
    tbl[7]  = '{857,  11'd857, 10'd0, 19'd799, 12'h000, 1'b0};
    tbl[8]  = '{858,  11'd858, 10'd0, 19'd799, 12'h000, 1'b1};
    tbl[9]  = '{977,  11'd977, 10'd0, 19'd799, 12'h000, 1'b1};
    tbl[10] = '{978,  11'd978, 10'd0, 19'd799, 12'h000, 1'b0};
    tbl[11] = '{1040, 11'd0,   10'd1, 19'd799, 12'h000, 1'b0};
    tbl[12] = '{1041, 11'd1,   10'd1, 19'd800, 12'h000, 1'b0};
    tbl[13] = '{1043, 11'd3,   10'd1, 19'd802, 12'hA05, 1'b0};

    RESET = 1'b1; PIX_EN = 1'b1;
    repeat (3) step(1'b1, 1'b1);

    // PIX_EN tied high: vector table plus per-line/per-frame rates.
    idx = 0;
    s_ft_count = 0; s_ft_n.delete();
    for (int k = 0; k < 2200; k++) begin
      step(1'b1, 1'b0);
      while (idx < 14 && tbl[idx].n == n) begin
        chk("tbl_h_cnt", 32'(b_h), 32'(tbl[idx].h));
        chk("tbl_v_cnt", 32'(b_v), 32'(tbl[idx].v));
        chk("tbl_fb_addr", 32'(b_a), 32'(tbl[idx].a));
        chk("tbl_vga_data", 32'(b_d), 32'(tbl[idx].d));
        chk("tbl_vga_h_out", 32'(b_ho), 32'(tbl[idx].ho));
        idx++;
      end
      if (n <= 1040 && b_ho === 1'b1) bh_cnt++;
      if (n <= 364 && s_vb === 1'b1) svb_cnt++;
      if (n >= 2 && n <= 365 && s_vo === 1'b1) svs_cnt++;
    end
    chk("tbl_consumed", 32'(idx), 32'd14);
    chk("hsync_ticks_per_line", bh_cnt, 32'd120);
    chk("vblank_ticks_per_frame", svb_cnt, 32'd196);
    chk("vsync_ticks_per_frame", svs_cnt, 32'd56);
    chk("frame_ticks_in_2200", s_ft_count, 32'd6);
    if (s_ft_n.size() >= 2) begin
      chk("first_frame_tick_at", s_ft_n[0], 32'd168);
      chk("frame_tick_spacing", s_ft_n[1] - s_ft_n[0], 32'd364);
    end else begin
      chk("frame_tick_pulses_seen", 32'(s_ft_n.size()), 32'd2);
    end

    // PIX_EN on every other CLK: state must only move on enabled cycles.
    for (int k = 0; k < 1000; k++) step(1'(k % 2 == 0), 1'b0);

    // Random PIX_EN density.
    for (int k = 0; k < 3000; k++) step(1'($urandom_range(0, 3) != 0), 1'b0);

    // Mid-frame reset at visible pixel (8,3) of the small raster.
    for (int k = 0; k < 2000 && (n % 364) != 92; k++) step(1'($urandom_range(0, 1)), 1'b0);
    chk("mid_reset_h", 32'(s_h), 32'd8);
    chk("mid_reset_v", 32'(s_v), 32'd3);
    step(1'($urandom_range(0, 1)), 1'b1);
    chk("post_reset_s_fb_addr", 32'(s_a), 32'd0);
    chk("post_reset_s_vga_data", 32'(s_d), 32'd0);
    step(1'b1, 1'b0);
    chk("restart_h", 32'(s_h), 32'd1);
    chk("restart_first_addr", 32'(s_a), 32'd0);
    step(1'b1, 1'b0);
    chk("restart_second_addr", 32'(s_a), 32'd1);
    s_ft_count = 0;
    for (int k = 0; k < 400 && n < 168; k++) step(1'b1, 1'b0);
    chk("no_frame_tick_before_vblank", s_ft_count, 32'd0);
    step(1'b1, 1'b0);
    chk("frame_tick_at_vblank_start", s_ft_count, 32'd1);

    for (int k = 0; k < 1500; k++) step(1'($urandom_range(0, 2) != 0), 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
